// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath blocks.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    // Sequencing states of the iterative InvSubBytes engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ibs_state_e;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: combinational byte lookup (FIPS-197 InvSbox).
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] a,
    output logic [AES_BYTE_W-1:0] c
);

    // Full 256-entry lookup table.
    always_comb begin
        c = 8'h00;
        case (a)
            8'h00: c = 8'h52; 8'h01: c = 8'h09; 8'h02: c = 8'h6a; 8'h03: c = 8'hd5;
            8'h04: c = 8'h30; 8'h05: c = 8'h36; 8'h06: c = 8'ha5; 8'h07: c = 8'h38;
            8'h08: c = 8'hbf; 8'h09: c = 8'h40; 8'h0a: c = 8'ha3; 8'h0b: c = 8'h9e;
            8'h0c: c = 8'h81; 8'h0d: c = 8'hf3; 8'h0e: c = 8'hd7; 8'h0f: c = 8'hfb;
            8'h10: c = 8'h7c; 8'h11: c = 8'he3; 8'h12: c = 8'h39; 8'h13: c = 8'h82;
            8'h14: c = 8'h9b; 8'h15: c = 8'h2f; 8'h16: c = 8'hff; 8'h17: c = 8'h87;
            8'h18: c = 8'h34; 8'h19: c = 8'h8e; 8'h1a: c = 8'h43; 8'h1b: c = 8'h44;
            8'h1c: c = 8'hc4; 8'h1d: c = 8'hde; 8'h1e: c = 8'he9; 8'h1f: c = 8'hcb;
            8'h20: c = 8'h54; 8'h21: c = 8'h7b; 8'h22: c = 8'h94; 8'h23: c = 8'h32;
            8'h24: c = 8'ha6; 8'h25: c = 8'hc2; 8'h26: c = 8'h23; 8'h27: c = 8'h3d;
            8'h28: c = 8'hee; 8'h29: c = 8'h4c; 8'h2a: c = 8'h95; 8'h2b: c = 8'h0b;
            8'h2c: c = 8'h42; 8'h2d: c = 8'hfa; 8'h2e: c = 8'hc3; 8'h2f: c = 8'h4e;
            8'h30: c = 8'h08; 8'h31: c = 8'h2e; 8'h32: c = 8'ha1; 8'h33: c = 8'h66;
            8'h34: c = 8'h28; 8'h35: c = 8'hd9; 8'h36: c = 8'h24; 8'h37: c = 8'hb2;
            8'h38: c = 8'h76; 8'h39: c = 8'h5b; 8'h3a: c = 8'ha2; 8'h3b: c = 8'h49;
            8'h3c: c = 8'h6d; 8'h3d: c = 8'h8b; 8'h3e: c = 8'hd1; 8'h3f: c = 8'h25;
            8'h40: c = 8'h72; 8'h41: c = 8'hf8; 8'h42: c = 8'hf6; 8'h43: c = 8'h64;
            8'h44: c = 8'h86; 8'h45: c = 8'h68; 8'h46: c = 8'h98; 8'h47: c = 8'h16;
            8'h48: c = 8'hd4; 8'h49: c = 8'ha4; 8'h4a: c = 8'h5c; 8'h4b: c = 8'hcc;
            8'h4c: c = 8'h5d; 8'h4d: c = 8'h65; 8'h4e: c = 8'hb6; 8'h4f: c = 8'h92;
            8'h50: c = 8'h6c; 8'h51: c = 8'h70; 8'h52: c = 8'h48; 8'h53: c = 8'h50;
            8'h54: c = 8'hfd; 8'h55: c = 8'hed; 8'h56: c = 8'hb9; 8'h57: c = 8'hda;
            8'h58: c = 8'h5e; 8'h59: c = 8'h15; 8'h5a: c = 8'h46; 8'h5b: c = 8'h57;
            8'h5c: c = 8'ha7; 8'h5d: c = 8'h8d; 8'h5e: c = 8'h9d; 8'h5f: c = 8'h84;
            8'h60: c = 8'h90; 8'h61: c = 8'hd8; 8'h62: c = 8'hab; 8'h63: c = 8'h00;
            8'h64: c = 8'h8c; 8'h65: c = 8'hbc; 8'h66: c = 8'hd3; 8'h67: c = 8'h0a;
            8'h68: c = 8'hf7; 8'h69: c = 8'he4; 8'h6a: c = 8'h58; 8'h6b: c = 8'h05;
            8'h6c: c = 8'hb8; 8'h6d: c = 8'hb3; 8'h6e: c = 8'h45; 8'h6f: c = 8'h06;
            8'h70: c = 8'hd0; 8'h71: c = 8'h2c; 8'h72: c = 8'h1e; 8'h73: c = 8'h8f;
            8'h74: c = 8'hca; 8'h75: c = 8'h3f; 8'h76: c = 8'h0f; 8'h77: c = 8'h02;
            8'h78: c = 8'hc1; 8'h79: c = 8'haf; 8'h7a: c = 8'hbd; 8'h7b: c = 8'h03;
            8'h7c: c = 8'h01; 8'h7d: c = 8'h13; 8'h7e: c = 8'h8a; 8'h7f: c = 8'h6b;
            8'h80: c = 8'h3a; 8'h81: c = 8'h91; 8'h82: c = 8'h11; 8'h83: c = 8'h41;
            8'h84: c = 8'h4f; 8'h85: c = 8'h67; 8'h86: c = 8'hdc; 8'h87: c = 8'hea;
            8'h88: c = 8'h97; 8'h89: c = 8'hf2; 8'h8a: c = 8'hcf; 8'h8b: c = 8'hce;
            8'h8c: c = 8'hf0; 8'h8d: c = 8'hb4; 8'h8e: c = 8'he6; 8'h8f: c = 8'h73;
            8'h90: c = 8'h96; 8'h91: c = 8'hac; 8'h92: c = 8'h74; 8'h93: c = 8'h22;
            8'h94: c = 8'he7; 8'h95: c = 8'had; 8'h96: c = 8'h35; 8'h97: c = 8'h85;
            8'h98: c = 8'he2; 8'h99: c = 8'hf9; 8'h9a: c = 8'h37; 8'h9b: c = 8'he8;
            8'h9c: c = 8'h1c; 8'h9d: c = 8'h75; 8'h9e: c = 8'hdf; 8'h9f: c = 8'h6e;
            8'ha0: c = 8'h47; 8'ha1: c = 8'hf1; 8'ha2: c = 8'h1a; 8'ha3: c = 8'h71;
            8'ha4: c = 8'h1d; 8'ha5: c = 8'h29; 8'ha6: c = 8'hc5; 8'ha7: c = 8'h89;
            8'ha8: c = 8'h6f; 8'ha9: c = 8'hb7; 8'haa: c = 8'h62; 8'hab: c = 8'h0e;
            8'hac: c = 8'haa; 8'had: c = 8'h18; 8'hae: c = 8'hbe; 8'haf: c = 8'h1b;
            8'hb0: c = 8'hfc; 8'hb1: c = 8'h56; 8'hb2: c = 8'h3e; 8'hb3: c = 8'h4b;
            8'hb4: c = 8'hc6; 8'hb5: c = 8'hd2; 8'hb6: c = 8'h79; 8'hb7: c = 8'h20;
            8'hb8: c = 8'h9a; 8'hb9: c = 8'hdb; 8'hba: c = 8'hc0; 8'hbb: c = 8'hfe;
            8'hbc: c = 8'h78; 8'hbd: c = 8'hcd; 8'hbe: c = 8'h5a; 8'hbf: c = 8'hf4;
            8'hc0: c = 8'h1f; 8'hc1: c = 8'hdd; 8'hc2: c = 8'ha8; 8'hc3: c = 8'h33;
            8'hc4: c = 8'h88; 8'hc5: c = 8'h07; 8'hc6: c = 8'hc7; 8'hc7: c = 8'h31;
            8'hc8: c = 8'hb1; 8'hc9: c = 8'h12; 8'hca: c = 8'h10; 8'hcb: c = 8'h59;
            8'hcc: c = 8'h27; 8'hcd: c = 8'h80; 8'hce: c = 8'hec; 8'hcf: c = 8'h5f;
            8'hd0: c = 8'h60; 8'hd1: c = 8'h51; 8'hd2: c = 8'h7f; 8'hd3: c = 8'ha9;
            8'hd4: c = 8'h19; 8'hd5: c = 8'hb5; 8'hd6: c = 8'h4a; 8'hd7: c = 8'h0d;
            8'hd8: c = 8'h2d; 8'hd9: c = 8'he5; 8'hda: c = 8'h7a; 8'hdb: c = 8'h9f;
            8'hdc: c = 8'h93; 8'hdd: c = 8'hc9; 8'hde: c = 8'h9c; 8'hdf: c = 8'hef;
            8'he0: c = 8'ha0; 8'he1: c = 8'he0; 8'he2: c = 8'h3b; 8'he3: c = 8'h4d;
            8'he4: c = 8'hae; 8'he5: c = 8'h2a; 8'he6: c = 8'hf5; 8'he7: c = 8'hb0;
            8'he8: c = 8'hc8; 8'he9: c = 8'heb; 8'hea: c = 8'hbb; 8'heb: c = 8'h3c;
            8'hec: c = 8'h83; 8'hed: c = 8'h53; 8'hee: c = 8'h99; 8'hef: c = 8'h61;
            8'hf0: c = 8'h17; 8'hf1: c = 8'h2b; 8'hf2: c = 8'h04; 8'hf3: c = 8'h7e;
            8'hf4: c = 8'hba; 8'hf5: c = 8'h77; 8'hf6: c = 8'hd6; 8'hf7: c = 8'h26;
            8'hf8: c = 8'he1; 8'hf9: c = 8'h69; 8'hfa: c = 8'h14; 8'hfb: c = 8'h63;
            8'hfc: c = 8'h55; 8'hfd: c = 8'h21; 8'hfe: c = 8'h0c; 8'hff: c = 8'h7d;
            default: c = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock,
// lowest byte indices first, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | substituting one slice of bytes per cycle
// DONE  | result presented, waiting for out_ready
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_state,
    output logic                   busy
);

    localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bpc_check
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    ibs_state_e             r_state;
    ibs_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [AES_BLOCK_W-1:0] r_data;
    logic [AES_BLOCK_W-1:0] w_data_nxt;
    logic [AES_BLOCK_W-1:0] w_sub_data;
    logic [AES_BYTE_W-1:0]  w_sb_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]  w_sb_out [BYTES_PER_CYCLE];

    // Pick the slice of bytes addressed by the step counter.
    always_comb begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_sb_in[g] = r_data[AES_BYTE_W*(int'(r_cnt)*BYTES_PER_CYCLE + g) +: AES_BYTE_W];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .a (w_sb_in[g]),
            .c (w_sb_out[g])
        );
    end

    // Write the substituted slice back in place; other bytes pass through.
    always_comb begin
        w_sub_data = r_data;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_sub_data[AES_BYTE_W*(int'(r_cnt)*BYTES_PER_CYCLE + g) +: AES_BYTE_W] = w_sb_out[g];
        end
    end

    // State, step counter and working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_data_nxt  = in_state;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                w_data_nxt = w_sub_data;
                if (r_cnt == LAST_STEP) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_state = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: S-box derived from GF(2^8) arithmetic,
// vector table, random blocks, handshake and reset corner cases.
module tb_inv_sub_bytes_iter;

    localparam int NUM_STEPS = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic         in_valid_x;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] out_state1;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] out_state16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd [256];
    logic [7:0] inv [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;
    vec_t vecs [8];

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready1),
        .in_state(in_state), .out_valid(out_valid1), .out_ready(1'b1),
        .out_state(out_state1), .busy(busy1)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready16),
        .in_state(in_state), .out_valid(out_valid16), .out_ready(1'b1),
        .out_state(out_state16), .busy(busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_block(logic [127:0] din);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv[din[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block through the default instance, checking latency and result.
    task automatic run_block(input string nm, input logic [127:0] din, input logic [127:0] dexp);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = din;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({nm, "_latency"}, 128'(lat), 128'(NUM_STEPS));
        chk({nm, "_data"}, out_state, dexp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_drop_valid"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        logic [127:0] blk, bexp, other;
        logic         saw_valid;
        logic [127:0] bq_in [3];
        logic [127:0] bq_exp [3];
        int           acc_t [3];
        int           n_acc, n_out, cyc, lat1, lat16, t;
        logic [127:0] d1, d16;

        for (int x = 0; x < 256; x++) begin
            fwd[x] = sbox(8'(x));
            inv[fwd[x]] = 8'(x);
        end

        rst = 1'b1; in_valid = 1'b0; in_valid_x = 1'b0; out_ready = 1'b0; in_state = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("reset_flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        chk("reset_alt_flags", 128'({out_valid1, busy1, in_ready1, out_valid16, busy16, in_ready16}),
            128'(6'b001001));

        vecs[0].din = 128'h0952ed16_00000000_00000000_7c63007c;
        vecs[0].dexp = 128'h404853ff_52525252_52525252_01005201;
        vecs[1].din = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
        vecs[1].dexp = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        vecs[2].din = 128'hffffffff_ffffffff_ffffffff_ffffffff;
        vecs[2].dexp = 128'h7d7d7d7d_7d7d7d7d_7d7d7d7d_7d7d7d7d;
        for (int i = 3; i < 8; i++) begin
            vecs[i].din  = rand_block();
            vecs[i].dexp = model_block(vecs[i].din);
        end
        for (int i = 0; i < 8; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].din, vecs[i].dexp);
        end

        // Round-trip every byte value through the forward S-box.
        for (int b = 0; b < 16; b++) begin
            for (int j = 0; j < 16; j++) begin
                blk[8*j +: 8]  = fwd[16*b + j];
                bexp[8*j +: 8] = 8'(16*b + j);
            end
            run_block($sformatf("roundtrip%0d", b), blk, bexp);
        end

        // Other widths: 1 byte/cycle and 16 bytes/cycle on the FIPS vector.
        in_state = vecs[1].din;
        in_valid_x = 1'b1;
        @(negedge clk);
        in_valid_x = 1'b0;
        lat1 = -1; lat16 = -1; d1 = '0; d16 = '0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid1 && lat1 < 0) begin lat1 = c; d1 = out_state1; end
            if (out_valid16 && lat16 < 0) begin lat16 = c; d16 = out_state16; end
            @(negedge clk);
        end
        chk("bpc1_latency", 128'(lat1), 128'(16));
        chk("bpc1_data", d1, vecs[1].dexp);
        chk("bpc16_latency", 128'(lat16), 128'(1));
        chk("bpc16_data", d16, vecs[1].dexp);

        // Backpressure: result held, second request refused.
        blk = rand_block();
        bexp = model_block(blk);
        other = rand_block();
        in_valid = 1'b1; in_state = blk;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_flags%0d", c), 128'({out_valid, in_ready, busy}), 128'(3'b101));
            chk($sformatf("bp_data%0d", c), out_state, bexp);
            if (c == 3) begin in_valid = 1'b1; in_state = other; end
            if (c == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));
        repeat (6) @(negedge clk);
        chk("bp_no_second", 128'({busy, out_valid}), 128'(2'b00));

        // Reset two cycles into RUN.
        in_valid = 1'b1; in_state = rand_block();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_no_output", 128'(saw_valid), 128'(0));
        blk = rand_block();
        run_block("after_rst", blk, model_block(blk));

        // Back-to-back with in_valid held and out_ready high.
        for (int i = 0; i < 3; i++) begin
            bq_in[i]  = rand_block();
            bq_exp[i] = model_block(bq_in[i]);
            acc_t[i]  = 0;
        end
        n_acc = 0; n_out = 0; cyc = 0;
        out_ready = 1'b1;
        while (n_out < 3 && cyc < 200) begin
            if (n_acc < 3) begin
                in_valid = 1'b1;
                in_state = bq_in[n_acc];
                if (in_ready) begin acc_t[n_acc] = cyc; n_acc++; end
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                chk($sformatf("b2b_data%0d", n_out), out_state, bq_exp[n_out]);
                n_out++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(n_out), 128'(3));
        chk("b2b_space01", 128'(acc_t[1] - acc_t[0]), 128'(NUM_STEPS + 2));
        chk("b2b_space12", 128'(acc_t[2] - acc_t[1]), 128'(NUM_STEPS + 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
